// File: rtl/execute_stage_pkg.sv
// Shared types for the execute stage: operand/control bundles, ALU and mul/div opcodes.
package definitions;

    localparam int MD_CYCLES = 32;

    typedef logic [31:0] Register;
    typedef logic [4:0]  RegAddr;

    // Zero encodings are ADD / NONE so an all-zero bundle decodes as a NOP.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } AluOp;

    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIVU = 2'd2,
        MD_REMU = 2'd3
    } MdOp;

    typedef struct packed {
        AluOp alu_op;
        logic use_imm;
        MdOp  md_op;
    } X_ctrl;

    typedef struct packed {
        X_ctrl   ctrl;
        Register pc;
        Register rs;
        Register rt;
        RegAddr  rs_addr;
        RegAddr  rt_addr;
        RegAddr  rd_addr;
        Register imm;
    } X_input;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_size;
    } XM_ctrl;

    typedef struct packed {
        XM_ctrl  ctrl;
        Register result;
        Register store_data;
        RegAddr  rd_addr;
    } M_input;

endpackage

// File: rtl/execute_stage_muldiv.sv
// Iterative 32-step multiply (MSB-first shift-add) and restoring divide unit.
module muldiv_iter
    import definitions::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    start,
    input  MdOp     op,
    input  Register a,
    input  Register b,
    output logic    busy,
    output logic    done,
    output Register result
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_t;

    localparam logic [4:0] LAST_STEP = 5'(MD_CYCLES - 1);

    md_state_t   state_reg, state_next;
    logic [4:0]  count_reg;
    MdOp         op_reg;
    Register     hi_reg;
    Register     lo_reg;
    Register     b_reg;

    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    Register     mul_next;

    // lo_reg shifts left for both ops: multiplier bits are consumed MSB first,
    // and quotient bits enter at the bottom as the dividend leaves the top.
    always_comb begin
        rem_shift = {hi_reg, lo_reg[31]};
        rem_diff  = rem_shift - {1'b0, b_reg};
        mul_next  = {hi_reg[30:0], 1'b0} + (lo_reg[31] ? b_reg : 32'h0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            op_reg    <= MD_NONE;
            hi_reg    <= '0;
            lo_reg    <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_reg    <= op;
                        lo_reg    <= a;
                        b_reg     <= b;
                        hi_reg    <= '0;
                        count_reg <= '0;
                    end
                end
                RUN: begin
                    count_reg <= count_reg + 5'd1;
                    lo_reg    <= {lo_reg[30:0], 1'b0};
                    if (op_reg == MD_MUL) begin
                        hi_reg <= mul_next;
                    end else if (!rem_diff[32]) begin
                        hi_reg    <= rem_diff[31:0];
                        lo_reg[0] <= 1'b1;
                    end else begin
                        hi_reg <= rem_shift[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = start;
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (count_reg == LAST_STEP) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign result = (op_reg == MD_DIVU) ? lo_reg : hi_reg;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU, iterative mul/div with stall request, and the X/M register.
module execute_stage
    import definitions::*;
#(
    parameter int XLEN = 32
) (
    input  logic    clk,
    input  logic    reset,
    input  X_input  x_in,
    input  XM_ctrl  xm_ctrl,
    output M_input  xm_out,
    output Register X_d,
    output logic    x_busy
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic [4:0]      shamt;

    logic            md_start;
    logic            md_busy;
    logic            md_done;
    Register         md_result;

    M_input          xm_reg;

    assign op_a  = x_in.rs;
    assign op_b  = x_in.ctrl.use_imm ? x_in.imm : x_in.rt;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_result = '0;
        case (x_in.ctrl.alu_op)
            ALU_ADD:  alu_result = op_a + op_b;
            ALU_SUB:  alu_result = op_a - op_b;
            ALU_AND:  alu_result = op_a & op_b;
            ALU_OR:   alu_result = op_a | op_b;
            ALU_XOR:  alu_result = op_a ^ op_b;
            ALU_NOR:  alu_result = ~(op_a | op_b);
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_SLL:  alu_result = op_a << shamt;
            ALU_SRL:  alu_result = op_a >> shamt;
            ALU_SRA:  alu_result = $signed(op_a) >>> shamt;
            ALU_LUI:  alu_result = {x_in.imm[15:0], 16'h0};
            default:  alu_result = '0;
        endcase
    end

    assign md_start = (x_in.ctrl.md_op != MD_NONE);

    muldiv_iter u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .op     (x_in.ctrl.md_op),
        .a      (x_in.rs),
        .b      (x_in.rt),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // Bubbles go downstream while the unit is busy; in DONE the held instruction
    // retires with the mul/div result instead of re-starting.
    always_ff @(posedge clk) begin
        if (reset) begin
            xm_reg <= '0;
        end else if (md_busy) begin
            xm_reg <= '0;
        end else if (md_done) begin
            xm_reg <= '{ctrl: xm_ctrl, result: md_result,
                        store_data: x_in.rt, rd_addr: x_in.rd_addr};
        end else begin
            xm_reg <= '{ctrl: xm_ctrl, result: alu_result,
                        store_data: x_in.rt, rd_addr: x_in.rd_addr};
        end
    end

    assign xm_out = xm_reg;
    assign X_d    = xm_reg.result;
    assign x_busy = md_busy;

endmodule

// File: tb/tb_execute_stage.sv
// Randomized self-checking bench for execute_stage against an arithmetic reference model.
module tb_execute_stage;
    import definitions::*;

    logic    clk = 1'b0;
    logic    reset;
    X_input  x_in;
    XM_ctrl  xm_ctrl;
    M_input  xm_out;
    Register X_d;
    logic    x_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    execute_stage #(.XLEN(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .x_in    (x_in),
        .xm_ctrl (xm_ctrl),
        .xm_out  (xm_out),
        .X_d     (X_d),
        .x_busy  (x_busy)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic Register ref_alu(AluOp op, logic use_imm, Register a, Register rt, Register imm);
        Register b;
        b = use_imm ? imm : rt;
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  return a << (b % 32);
            ALU_SRL:  return a >> (b % 32);
            ALU_SRA:  return Register'($signed(a) >>> (b % 32));
            ALU_LUI:  return (imm % 65536) * 65536;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic Register ref_md(MdOp op, Register a, Register b);
        logic [63:0] p;
        p = {32'h0, a} * {32'h0, b};
        case (op)
            MD_MUL:  return p[31:0];
            MD_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MD_REMU: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic set_instr(input AluOp aop, input logic use_imm, input MdOp mop,
                             input Register rs, input Register rt, input Register imm,
                             input RegAddr rd, input XM_ctrl xc);
        x_in              = '0;
        x_in.ctrl.alu_op  = aop;
        x_in.ctrl.use_imm = use_imm;
        x_in.ctrl.md_op   = mop;
        x_in.pc           = $urandom;
        x_in.rs           = rs;
        x_in.rt           = rt;
        x_in.rs_addr      = RegAddr'($urandom_range(0, 31));
        x_in.rt_addr      = RegAddr'($urandom_range(0, 31));
        x_in.rd_addr      = rd;
        x_in.imm          = imm;
        xm_ctrl           = xc;
    endtask

    task automatic check_result(input string tag, input Register exp, input Register rt,
                                input RegAddr rd, input XM_ctrl xc);
        check_eq({tag, ".result"}, xm_out.result, exp);
        check_eq({tag, ".X_d"}, X_d, exp);
        check_eq({tag, ".store_data"}, xm_out.store_data, rt);
        check_eq({tag, ".rd"}, xm_out.rd_addr, rd);
        check_eq({tag, ".ctrl"}, xm_out.ctrl, xc);
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic run_alu(input AluOp aop, input logic use_imm, input Register rs,
                           input Register rt, input Register imm);
        RegAddr  rd;
        XM_ctrl  xc;
        Register exp;
        rd  = RegAddr'($urandom_range(0, 31));
        xc  = XM_ctrl'($urandom_range(0, 31));
        exp = ref_alu(aop, use_imm, rs, rt, imm);
        set_instr(aop, use_imm, MD_NONE, rs, rt, imm, rd, xc);
        #1;
        check_eq("alu_busy", x_busy, 1'b0);
        @(posedge clk);
        #1;
        check_result("alu", exp, rt, rd, xc);
        $display("txn alu op=%s imm=%0d rs=%h rt=%h imm=%h exp=%h got=%h",
                 aop.name(), use_imm, rs, rt, imm, exp, xm_out.result);
    endtask

    task automatic run_md(input MdOp mop, input Register a, input Register b, input logic perturb);
        RegAddr  rd;
        XM_ctrl  xc;
        Register exp;
        int      n_busy;
        int      k;
        rd     = RegAddr'($urandom_range(0, 31));
        xc     = XM_ctrl'($urandom_range(0, 31));
        exp    = ref_md(mop, a, b);
        n_busy = 0;
        k      = 0;
        set_instr(AluOp'($urandom_range(0, 11)), 1'b0, mop, a, b, $urandom, rd, xc);
        #1;
        while (x_busy && k < 40) begin
            n_busy++;
            if (perturb && k > 0) begin
                x_in.rs = $urandom;
                x_in.rt = $urandom;
            end
            @(posedge clk);
            #1;
            check_eq("md_bubble", xm_out, '0);
            k++;
        end
        x_in.rs = a;
        x_in.rt = b;
        check_eq("md_busy_cycles", n_busy, 33);
        @(posedge clk);
        #1;
        check_result("md", exp, b, rd, xc);
        $display("txn md op=%s a=%h b=%h busy=%0d exp=%h got=%h",
                 mop.name(), a, b, n_busy, exp, xm_out.result);
    endtask

    initial begin
        reset   = 1'b1;
        x_in    = '0;
        xm_ctrl = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("reset_xm_out", xm_out, '0);
        check_eq("reset_X_d", X_d, 32'h0);
        check_eq("reset_busy", x_busy, 1'b0);
        $display("txn reset");

        run_alu(ALU_ADD, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h0);
        check_eq("add_wrap_const", xm_out.result, 32'h8000_0000);
        run_alu(ALU_SLT, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h0);
        check_eq("slt_const", xm_out.result, 32'h0);
        run_alu(ALU_SLTU, 1'b0, 32'h1, 32'hFFFF_FFFF, 32'h0);
        check_eq("sltu_const", xm_out.result, 32'h1);
        run_alu(ALU_SRA, 1'b1, 32'h8000_0000, 32'h0, 32'h4);
        check_eq("sra_const", xm_out.result, 32'hF800_0000);
        run_alu(ALU_LUI, 1'b1, 32'h0, 32'h0, 32'h1234);
        check_eq("lui_const", xm_out.result, 32'h1234_0000);

        run_md(MD_MUL, 32'h0001_0003, 32'h0002_0005, 1'b1);
        check_eq("mul_const", xm_out.result, 32'h000B_000F);
        run_md(MD_DIVU, 32'd100, 32'd7, 1'b1);
        check_eq("divu_const", xm_out.result, 32'd14);
        run_md(MD_REMU, 32'd100, 32'd7, 1'b0);
        check_eq("remu_const", xm_out.result, 32'd2);
        run_md(MD_DIVU, 32'd100, 32'd0, 1'b0);
        check_eq("divu0_const", xm_out.result, 32'hFFFF_FFFF);
        run_md(MD_REMU, 32'd5, 32'd0, 1'b1);
        check_eq("remu0_const", xm_out.result, 32'd5);

        // Reset at RUN count 10: the op enters at T, count 10 is cycle T+11.
        set_instr(ALU_ADD, 1'b0, MD_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 5'd3, 5'h1F);
        repeat (11) @(posedge clk);
        #1;
        reset   = 1'b1;
        x_in    = '0;
        xm_ctrl = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("midrun_reset_xm_out", xm_out, '0);
        check_eq("midrun_reset_busy", x_busy, 1'b0);
        $display("txn reset during mul run");
        run_alu(ALU_ADD, 1'b0, 32'd40, 32'd2, 32'h0);

        // DIVU directly followed by ADD; back-to-back mul/div.
        run_md(MD_DIVU, 32'd1000, 32'd3, 1'b0);
        run_alu(ALU_ADD, 1'b0, 32'hDEAD_0000, 32'h0000_BEEF, 32'h0);
        check_eq("post_div_add_const", xm_out.result, 32'hDEAD_BEEF);
        run_md(MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_md(MD_REMU, 32'hFFFF_FFFF, 32'h0001_0000, 1'b1);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                run_md(MdOp'($urandom_range(1, 3)), $urandom,
                       ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31)),
                       1'b1);
            end else begin
                run_alu(AluOp'($urandom_range(0, 11)), 1'($urandom_range(0, 1)),
                        $urandom, $urandom, $urandom);
            end
        end

        x_in    = '0;
        xm_ctrl = '0;
        @(posedge clk);
        #1;
        check_eq("bubble_xm_out", xm_out, '0);
        check_eq("bubble_busy", x_busy, 1'b0);
        $display("txn bubble");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
